rx_frame_ctrl: RTL

Controller and buffer on the receive side of the UART. It owns the receiver configuration: parity enable/type and receiver enable. New configuration is applied only between frames, so a frame in flight is never decoded with mixed settings. It also buffers completed frames in a small first-word-fall-through FIFO with a valid/ready consumer handshake, and reports overrun and line-error status.

---
 rtl/uart_rx_pkg.sv | 22 ++
 rtl/rx_frame_ctrl_if.sv | 57 +++++
 rtl/rx_frame_fifo.sv | 63 ++++++
 rtl/rx_frame_ctrl.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared types and constants for the UART receive-side controller.
// Holds the controller state enum, parity type encodings, the error counter
// width and a saturating-increment helper for those counters.
package uart_rx_pkg;

   typedef enum logic [1:0] {
      DISABLED = 2'd0,
      ACTIVE   = 2'd1,
      DRAIN    = 2'd2
   } rx_ctrl_state_t;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   localparam int ERR_CNT_W = 8;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/rx_frame_ctrl_if.sv
// rx_frame_ctrl_if: bundle of every non-clock signal of rx_frame_ctrl.
// Ports: configuration request/applied fields, RX FSM status and frame pulses,
// FIFO consumer handshake (Out_*), status (Overrun, error counters, Clr_Status).
// modport slave is the controller; modport master is the RX FSM / consumer side.
interface rx_frame_ctrl_if #(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 4
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   // configuration
   logic                  Cfg_Write;
   logic                  Cfg_Rx_Enable;
   logic                  Cfg_Parity_Enable;
   logic                  Cfg_Parity_Type;
   logic                  Cfg_Busy;
   logic                  Rx_Enable;
   logic                  Parity_Enable;
   logic                  Parity_Type;
   // receiver side
   logic                  Rx_Busy;
   logic [DATA_WIDTH-1:0] Rx_Data;
   logic                  Rx_Data_Valid;
   logic                  Rx_Parity_Error;
   logic                  Rx_Stop_Error;
   // consumer side
   logic [DATA_WIDTH-1:0] Out_Data;
   logic                  Out_Valid;
   logic                  Out_Ready;
   logic [CW-1:0]         Fifo_Count;
   // status
   logic                  Overrun;
   logic                  Clr_Status;
   logic [7:0]            Parity_Err_Cnt;
   logic [7:0]            Stop_Err_Cnt;

   modport slave (
      input  Cfg_Write, Cfg_Rx_Enable, Cfg_Parity_Enable, Cfg_Parity_Type,
      output Cfg_Busy, Rx_Enable, Parity_Enable, Parity_Type,
      input  Rx_Busy, Rx_Data, Rx_Data_Valid, Rx_Parity_Error, Rx_Stop_Error,
      output Out_Data, Out_Valid, Fifo_Count,
      input  Out_Ready,
      output Overrun, Parity_Err_Cnt, Stop_Err_Cnt,
      input  Clr_Status
   );

   modport master (
      output Cfg_Write, Cfg_Rx_Enable, Cfg_Parity_Enable, Cfg_Parity_Type,
      input  Cfg_Busy, Rx_Enable, Parity_Enable, Parity_Type,
      output Rx_Busy, Rx_Data, Rx_Data_Valid, Rx_Parity_Error, Rx_Stop_Error,
      input  Out_Data, Out_Valid, Fifo_Count,
      output Out_Ready,
      input  Overrun, Parity_Err_Cnt, Stop_Err_Cnt,
      output Clr_Status
   );

endinterface

// File: rtl/rx_frame_fifo.sv
// rx_frame_fifo: first-word-fall-through frame buffer with a registered head.
// Latency: write into an empty FIFO shows at head/not_empty one cycle later.
// Backpressure: caller only writes when !full or reading in the same cycle.
// Ports: CLK, RST (sync, active-high), wr/wr_data, rd, head, not_empty, full, count.
module rx_frame_fifo #(
   parameter  int DATA_WIDTH = 8,
   parameter  int FIFO_DEPTH = 4,
   localparam int AW         = $clog2(FIFO_DEPTH)
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  wr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd,
   output logic [DATA_WIDTH-1:0] head,
   output logic                  not_empty,
   output logic                  full,
   output logic [AW:0]           count
);

   localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW:0]           wr_ptr;
   logic [AW:0]           rd_ptr;
   logic [AW-1:0]         rd_idx_next;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign count       = wr_ptr - rd_ptr;
   assign not_empty   = (wr_ptr != rd_ptr);
   assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign rd_idx_next = rd_ptr[AW-1:0] + 1'b1;

   // Storage needs no reset: entries are only observed through head.
   always_ff @(posedge CLK) begin
      if (wr) begin
         mem[wr_ptr[AW-1:0]] <= wr_data;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         head   <= '0;
      end else begin
         if (wr) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         // Head reloads from the incoming word when it becomes the oldest
         // entry, otherwise from the next stored slot after a pop.
         if (wr && (!not_empty || (rd && count == CNT_ONE))) begin
            head <= wr_data;
         end else if (rd && count > CNT_ONE) begin
            head <= mem[rd_idx_next];
         end
      end
   end

endmodule

// File: rtl/rx_frame_ctrl.sv
// rx_frame_ctrl: UART receive-side config owner, frame buffer and status block.
// Latency: idle config apply and frame-to-Out_Valid are both one cycle.
// Backpressure: Out_Valid/Out_Ready; a good frame arriving with no space is dropped and sets Overrun.
// Ports: CLK, RST (sync, active-high), bus (rx_frame_ctrl_if.slave).
// Optional: define RX_FRAME_ERR_CNT_EN to build the saturating parity/stop error counters;
// otherwise Parity_Err_Cnt and Stop_Err_Cnt are tied to 0.
module rx_frame_ctrl
   import uart_rx_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic           CLK,
   input  logic           RST,
   rx_frame_ctrl_if.slave bus
);

   rx_ctrl_state_t state, state_nxt;

   logic sh_en, sh_pen, sh_ptype;
   logic rx_en_q, par_en_q, par_type_q;
   logic shadow_ld;
   logic apply;
   logic ap_en, ap_pen, ap_ptype;

   // Config FSM: a write applies at once unless a frame is in flight while
   // receiving; then it waits in DRAIN for the RX FSM to go idle.
   always_comb begin
      state_nxt = state;
      shadow_ld = 1'b0;
      apply     = 1'b0;
      ap_en     = sh_en;
      ap_pen    = sh_pen;
      ap_ptype  = sh_ptype;
      if (bus.Cfg_Write) begin
         shadow_ld = 1'b1;
         if (state == DISABLED || !bus.Rx_Busy) begin
            apply    = 1'b1;
            ap_en    = bus.Cfg_Rx_Enable;
            ap_pen   = bus.Cfg_Parity_Enable;
            ap_ptype = bus.Cfg_Parity_Type;
         end else begin
            state_nxt = DRAIN;
         end
      end else if (state == DRAIN && !bus.Rx_Busy) begin
         apply = 1'b1;
      end
      if (apply) begin
         state_nxt = ap_en ? ACTIVE : DISABLED;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= DISABLED;
         sh_en      <= 1'b0;
         sh_pen     <= 1'b0;
         sh_ptype   <= PAR_EVEN;
         rx_en_q    <= 1'b0;
         par_en_q   <= 1'b0;
         par_type_q <= PAR_EVEN;
      end else begin
         state <= state_nxt;
         if (shadow_ld) begin
            sh_en    <= bus.Cfg_Rx_Enable;
            sh_pen   <= bus.Cfg_Parity_Enable;
            sh_ptype <= bus.Cfg_Parity_Type;
         end
         if (apply) begin
            rx_en_q    <= ap_en;
            par_en_q   <= ap_pen;
            par_type_q <= ap_ptype;
         end
      end
   end

   assign bus.Cfg_Busy      = (state == DRAIN);
   assign bus.Rx_Enable     = rx_en_q;
   assign bus.Parity_Enable = par_en_q;
   assign bus.Parity_Type   = par_type_q;

   // Frame buffering: frames count in ACTIVE and DRAIN; a same-cycle pop frees a slot.
   logic accept, fifo_full, fifo_ne, fifo_wr, fifo_rd, wr_req, ovr_set;

   assign accept  = (state != DISABLED);
   assign fifo_rd = fifo_ne && bus.Out_Ready;
   assign wr_req  = bus.Rx_Data_Valid && accept;
   assign fifo_wr = wr_req && (!fifo_full || fifo_rd);
   assign ovr_set = wr_req && fifo_full && !fifo_rd;

   rx_frame_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .CLK       (CLK),
      .RST       (RST),
      .wr        (fifo_wr),
      .wr_data   (bus.Rx_Data),
      .rd        (fifo_rd),
      .head      (bus.Out_Data),
      .not_empty (fifo_ne),
      .full      (fifo_full),
      .count     (bus.Fifo_Count)
   );

   assign bus.Out_Valid = fifo_ne;

   // Status: a set event beats a coincident clear.
   logic overrun_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         overrun_q <= 1'b0;
      end else if (ovr_set) begin
         overrun_q <= 1'b1;
      end else if (bus.Clr_Status) begin
         overrun_q <= 1'b0;
      end
   end

   assign bus.Overrun = overrun_q;

`ifdef RX_FRAME_ERR_CNT_EN
   logic [ERR_CNT_W-1:0] par_cnt, stop_cnt;
   logic                 par_set, stop_set;

   assign par_set  = bus.Rx_Parity_Error && accept;
   assign stop_set = bus.Rx_Stop_Error && accept;

   always_ff @(posedge CLK) begin
      if (RST) begin
         par_cnt  <= '0;
         stop_cnt <= '0;
      end else begin
         if (par_set) begin
            par_cnt <= bus.Clr_Status ? ERR_CNT_W'(1) : sat_inc(par_cnt);
         end else if (bus.Clr_Status) begin
            par_cnt <= '0;
         end
         if (stop_set) begin
            stop_cnt <= bus.Clr_Status ? ERR_CNT_W'(1) : sat_inc(stop_cnt);
         end else if (bus.Clr_Status) begin
            stop_cnt <= '0;
         end
      end
   end

   assign bus.Parity_Err_Cnt = par_cnt;
   assign bus.Stop_Err_Cnt   = stop_cnt;
`else
   logic unused_err_pulses;
   assign unused_err_pulses  = bus.Rx_Parity_Error ^ bus.Rx_Stop_Error;
   assign bus.Parity_Err_Cnt = '0;
   assign bus.Stop_Err_Cnt   = '0;
`endif

endmodule
